rhd_spi_responder: RTL and testbench

//  Synthesizable RHD2000-style SPI responder: the chip end of the link driven by the rhd AXI controller.

---
 rtl/rhd_spi_if.sv | 10 +
 rtl/rhd_spi_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_rhd_spi_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rhd_spi_if.sv
// SPI pin bundle between the rhd controller (master) and the chip-side responder (slave).
interface rhd_spi_if;
  logic CS;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output CS, output SCLK, output MOSI, input MISO);
  modport slave  (input CS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/rhd_spi_responder.sv
// RHD2000-style SPI responder: oversamples the SPI pins on aclk, decodes 16-bit commands and
// returns command n's result during frame n+2. Optional MISO delay line under RHD_MISO_DELAY_EN.
//
// state    | meaning
// ST_IDLE  | CS high, waiting for a CS fall
// ST_SHIFT | frame in progress, shifting MOSI in and MISO out
// ST_EXEC  | one-cycle slot after CS rise carrying the cmd_valid/frame_err pulse
module rhd_spi_responder #(
  parameter int         NUM_CH   = 32,
  parameter logic [7:0] CHIP_ID  = 8'h01,
  parameter int         MISO_DLY = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  rhd_spi_if.slave    spi,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        frame_err,
  output logic        calib_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam int          NUM_REGS     = 18;
  localparam logic [15:0] CMD_CALIB    = 16'h5500;
  localparam logic [15:0] CMD_CLEAR    = 16'h6A00;
  localparam logic [3:0]  CALIB_FRAMES = 4'd9;
  localparam logic [7:0]  NUM_CH_B     = 8'(NUM_CH);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_t      state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic [15:0] tx_sr_q, tx_sr_d;
  logic [15:0] r0_q, r0_d, r1_q, r1_d;
  logic [15:0] cmd_word_q, cmd_word_d;
  logic [9:0]  seq_q, seq_d;
  logic [3:0]  calib_cnt_q, calib_cnt_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  logic [1:0]  op;
  logic [5:0]  addr;
  logic [7:0]  data;
  logic [7:0]  rd_val;
  logic [15:0] result;
  logic        in_calib;
  logic        miso_core;

  // CS idles high so a reset release with CS high never looks like a frame start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= spi.CS;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= spi.SCLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi.MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign cs_fall   =  cs_prev_q   & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q   &  cs_sync_q;
  assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

  assign op       = rx_sr_q[15:14];
  assign addr     = rx_sr_q[13:8];
  assign data     = rx_sr_q[7:0];
  assign in_calib = (calib_cnt_q != 4'd0);

  always_comb begin
    rd_val = 8'h00;
    if (int'(addr) < NUM_REGS) begin
      rd_val = regs_q[addr[4:0]];
    end else begin
      case (addr)
        6'd40:        rd_val = 8'h49;
        6'd41:        rd_val = 8'h4E;
        6'd42:        rd_val = 8'h54;
        6'd43:        rd_val = 8'h41;
        6'd44:        rd_val = 8'h4E;
        6'd60, 6'd61: rd_val = 8'h01;
        6'd62:        rd_val = NUM_CH_B;
        6'd63:        rd_val = CHIP_ID;
        default:      rd_val = 8'h00;
      endcase
    end
  end

  always_comb begin
    result = 16'h0000;
    case (op)
      2'b00: begin
        if (!in_calib && (int'(addr) < NUM_CH)) result = {addr, seq_q};
      end
      2'b10:   result = {8'hFF, data};
      2'b11:   result = {8'h00, rd_val};
      default: result = 16'h0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    cmd_word_d  = cmd_word_q;
    seq_d       = seq_q;
    calib_cnt_d = calib_cnt_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_SHIFT;
          bitcnt_d = 5'd0;
          tx_sr_d  = r1_q;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_EXEC;
          tx_sr_d = 16'h0000;
          if (bitcnt_q == 5'd16) begin
            cmd_valid_d = 1'b1;
            cmd_word_d  = rx_sr_q;
            r1_d        = r0_q;
            r0_d        = result;
            if (in_calib) calib_cnt_d = calib_cnt_q - 4'd1;
            case (op)
              2'b00: begin
                if (!in_calib && addr == 6'd0) seq_d = seq_q + 10'd1;
              end
              2'b01: begin
                if (rx_sr_q == CMD_CALIB) calib_cnt_d = CALIB_FRAMES;
                if (rx_sr_q == CMD_CLEAR) seq_d = 10'd0;
              end
              2'b10: begin
                if (int'(addr) < NUM_REGS) regs_d[addr[4:0]] = data;
              end
              default: ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_sr_d = {rx_sr_q[14:0], mosi_sync_q};
            if (bitcnt_q != 5'd16) bitcnt_d = bitcnt_q + 5'd1;
          end
          // Zero fill makes MISO hold 0 once all 16 result bits are out.
          if (sclk_fall) tx_sr_d = {tx_sr_q[14:0], 1'b0};
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 5'd0;
      rx_sr_q     <= 16'h0000;
      tx_sr_q     <= 16'h0000;
      r0_q        <= 16'h0000;
      r1_q        <= 16'h0000;
      cmd_word_q  <= 16'h0000;
      seq_q       <= 10'd0;
      calib_cnt_q <= 4'd0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      cmd_word_q  <= cmd_word_d;
      seq_q       <= seq_d;
      calib_cnt_q <= calib_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_word   = cmd_word_q;
  assign frame_err  = frame_err_q;
  assign calib_busy = in_calib;
  assign miso_core  = tx_sr_q[15];

`ifdef RHD_MISO_DELAY_EN
  if (MISO_DLY == 0) begin : g_miso_direct
    assign spi.MISO = miso_core;
  end else begin : g_miso_delay
    logic [MISO_DLY-1:0] dly_q;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) dly_q <= '0;
      else          dly_q <= (dly_q << 1) | MISO_DLY'(miso_core);
    end
    assign spi.MISO = dly_q[MISO_DLY-1];
  end
`else
  // MISO_DLY has no effect in this build; any legal value gives the direct path.
  if (MISO_DLY >= 0) begin : g_miso_direct
    assign spi.MISO = miso_core;
  end
`endif

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Bench for rhd_spi_responder: directed and random SPI frames against a behavioural chip model.
module tb_rhd_spi_responder;
  localparam int         NUM_CH  = 32;
  localparam logic [7:0] CHIP_ID = 8'h01;
  localparam int         HALF    = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid, frame_err, calib_busy;
  logic [15:0] cmd_word;

  always #5 aclk = ~aclk;

  rhd_spi_if spi ();

  rhd_spi_responder #(.NUM_CH(NUM_CH), .CHIP_ID(CHIP_ID), .MISO_DLY(0)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .spi        (spi),
    .cmd_valid  (cmd_valid),
    .cmd_word   (cmd_word),
    .frame_err  (frame_err),
    .calib_busy (calib_busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;
  int          n_ferr = 0;
  logic [15:0] last_word = 16'h0000;

  always @(negedge aclk) begin
    if (cmd_valid) begin
      n_valid++;
      last_word = cmd_word;
    end
    if (frame_err) n_ferr++;
  end

  // Behavioural chip model: register file, sample counter, calibration window, two-deep result queue.
  logic [7:0]  mem [18];
  int          seq_m;
  int          calib_left;
  logic [15:0] pipe [$];

  task automatic model_reset();
    for (int i = 0; i < 18; i++) mem[i] = 8'h00;
    seq_m = 0;
    calib_left = 0;
    pipe.delete();
    pipe.push_back(16'h0000);
    pipe.push_back(16'h0000);
  endtask

  function automatic logic [7:0] model_read(input int a);
    string name = "INTAN";
    if (a < 18) return mem[a];
    if (a >= 40 && a <= 44) return name[a-40];
    if (a == 60 || a == 61) return 8'h01;
    if (a == 62) return 8'(NUM_CH);
    if (a == 63) return CHIP_ID;
    return 8'h00;
  endfunction

  task automatic model_cmd(input logic [15:0] w, output logic [15:0] res);
    int op   = int'(w[15:14]);
    int a    = int'(w[13:8]);
    int d    = int'(w[7:0]);
    bit busy = (calib_left > 0);
    res = 16'h0000;
    if (busy) calib_left--;
    case (op)
      0: if (!busy) begin
           if (a < NUM_CH) res = 16'(a * 1024 + seq_m);
           if (a == 0) seq_m = (seq_m + 1) % 1024;
         end
      1: begin
           if (w == 16'h5500) calib_left = 9;
           if (w == 16'h6A00) seq_m = 0;
         end
      2: begin
           if (a < 18) mem[a] = 8'(d);
           res = 16'(16'hFF00 + d);
         end
      default: res = {8'h00, model_read(a)};
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI frame of nbits clocks; checks MISO, pulses and calib_busy against the model.
  task automatic frame(input logic [15:0] w, input int nbits, output logic [15:0] got);
    int          v0 = n_valid;
    int          e0 = n_ferr;
    logic [15:0] sh = w;
    logic [15:0] exp_tx = pipe[0];
    logic [15:0] res;
    got = 16'h0000;
    @(negedge aclk);
    spi.CS   = 1'b0;
    spi.MOSI = sh[15];
    for (int i = 0; i < nbits; i++) begin
      repeat (HALF) @(negedge aclk);
      got = {got[14:0], spi.MISO};
      spi.SCLK = 1'b1;
      repeat (HALF) @(negedge aclk);
      spi.SCLK = 1'b0;
      sh = sh << 1;
      spi.MOSI = sh[15];
    end
    repeat (HALF) @(negedge aclk);
    spi.CS = 1'b1;
    repeat (10) @(negedge aclk);
    chk("miso", 32'(got), 32'(exp_tx >> (16 - nbits)));
    if (nbits == 16) begin
      model_cmd(w, res);
      void'(pipe.pop_front());
      pipe.push_back(res);
      chk("cmd_valid_pulses", 32'(n_valid - v0), 32'd1);
      chk("frame_err_quiet", 32'(n_ferr - e0), 32'd0);
      chk("cmd_word", 32'(last_word), 32'(w));
      chk("miso_idle", 32'(spi.MISO), 32'd0);
    end else begin
      chk("cmd_valid_quiet", 32'(n_valid - v0), 32'd0);
      chk("frame_err_pulses", 32'(n_ferr - e0), 32'd1);
    end
    chk("calib_busy", 32'(calib_busy), 32'(calib_left > 0));
  endtask

  logic [15:0] got;
  logic [15:0] w;
  int          nb;
  int          v_save, e_save;

  initial begin
    spi.CS = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    model_reset();
    repeat (5) @(negedge aclk);
    chk("rst_miso", 32'(spi.MISO), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_word", 32'(cmd_word), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_calib_busy", 32'(calib_busy), 32'd0);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);

    // Identification reads
    frame(16'hE800, 16, got); chk("rd40_f1", 32'(got), 32'h0000);
    frame(16'hE900, 16, got); chk("rd41_f2", 32'(got), 32'h0000);
    frame(16'hEA00, 16, got); chk("rd42_f3", 32'(got), 32'h0049);
    frame(16'hFF00, 16, got); chk("rd_dummy1", 32'(got), 32'h004E);
    frame(16'hFF00, 16, got); chk("rd_dummy2", 32'(got), 32'h0054);

    // Write then read back; read-only region ignores writes
    frame(16'h8312, 16, got);
    frame(16'hC300, 16, got);
    frame(16'hFF00, 16, got); chk("wr3_echo", 32'(got), 32'hFF12);
    frame(16'hFF00, 16, got); chk("rd3_value", 32'(got), 32'h0012);
    frame(16'hA812, 16, got);
    frame(16'hE800, 16, got);
    frame(16'hFF00, 16, got); chk("wr40_echo", 32'(got), 32'hFF12);
    frame(16'hFF00, 16, got); chk("rd40_unchanged", 32'(got), 32'h0049);

    // Conversions
    frame(16'h0000, 16, got);
    frame(16'h0000, 16, got);
    frame(16'h0000, 16, got); chk("conv0_a", 32'(got), 32'h0000);
    frame(16'h0500, 16, got); chk("conv0_b", 32'(got), 32'h0001);
    frame(16'h2800, 16, got); chk("conv0_c", 32'(got), 32'h0002);
    frame(16'hFF00, 16, got); chk("conv5", 32'(got), 32'h1403);
    frame(16'hFF00, 16, got); chk("conv40", 32'(got), 32'h0000);

    // Calibration window
    frame(16'h6A00, 16, got);
    frame(16'h5500, 16, got);
    for (int i = 0; i < 9; i++) begin
      frame(16'h0000, 16, got);
      if (i < 8) chk("calib_busy_window", 32'(calib_busy), 32'd1);
      if (i >= 2) chk("calib_conv_zero", 32'(got), 32'h0000);
    end
    chk("calib_busy_end", 32'(calib_busy), 32'd0);
    frame(16'h0000, 16, got); chk("calib_conv_zero_8", 32'(got), 32'h0000);
    frame(16'h0000, 16, got); chk("calib_conv_zero_9", 32'(got), 32'h0000);
    frame(16'hFF00, 16, got); chk("post_calib_seq0", 32'(got), 32'h0000);
    frame(16'hFF00, 16, got); chk("post_calib_seq1", 32'(got), 32'h0001);

    // Short frames leave the pipeline alone
    frame(16'hC300, 16, got);
    frame(16'h0000, 10, got);
    frame(16'h0000, 0, got);
    frame(16'hFF00, 16, got);
    frame(16'hFF00, 16, got); chk("after_abort", 32'(got), 32'h0012);

    // SCLK activity with CS high is ignored
    v_save = n_valid;
    e_save = n_ferr;
    for (int i = 0; i < 6; i++) begin
      spi.MOSI = 1'($urandom);
      repeat (HALF) @(negedge aclk);
      spi.SCLK = 1'b1;
      repeat (HALF) @(negedge aclk);
      spi.SCLK = 1'b0;
    end
    repeat (8) @(negedge aclk);
    chk("cs_high_sclk_valid", 32'(n_valid - v_save), 32'd0);
    chk("cs_high_sclk_err", 32'(n_ferr - e_save), 32'd0);
    frame(16'hFF00, 16, got);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    w = {2'b00, 6'($urandom_range(0, 40)), 8'($urandom)};
        2:       w = 16'h5500;
        3:       w = 16'h6A00;
        4, 5:    w = {2'b10, 6'($urandom_range(0, 63)), 8'($urandom)};
        6, 7:    w = {2'b11, 6'($urandom_range(0, 63)), 8'($urandom)};
        default: w = 16'($urandom);
      endcase
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 16;
      frame(w, nb, got);
    end

    // Reset in the middle of a frame
    v_save = n_valid;
    e_save = n_ferr;
    @(negedge aclk);
    spi.CS = 1'b0;
    for (int i = 0; i < 7; i++) begin
      spi.MOSI = 1'($urandom);
      repeat (HALF) @(negedge aclk);
      spi.SCLK = 1'b1;
      repeat (HALF) @(negedge aclk);
      spi.SCLK = 1'b0;
    end
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    chk("midrst_miso", 32'(spi.MISO), 32'd0);
    chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("midrst_cmd_word", 32'(cmd_word), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_calib_busy", 32'(calib_busy), 32'd0);
    spi.CS = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    repeat (8) @(negedge aclk);
    chk("midrst_no_valid", 32'(n_valid - v_save), 32'd0);
    chk("midrst_no_err", 32'(n_ferr - e_save), 32'd0);
    frame(16'hC300, 16, got); chk("postrst_f1", 32'(got), 32'h0000);
    frame(16'h0000, 16, got); chk("postrst_f2", 32'(got), 32'h0000);
    frame(16'hFF00, 16, got); chk("postrst_reg3", 32'(got), 32'h0000);
    frame(16'hFF00, 16, got); chk("postrst_seq", 32'(got), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
